// File: rtl/inertial_path_delay.sv
// inertial_path_delay
// Clocked model of a single module path delay with separate rise/fall
// delays and inertial rejection of short pulses. A cancelled transition
// can be flagged on out_x, either when the cancel is detected or when the
// cancelled edge would have happened. A saturating counter tracks cancels.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   din        path input, sampled every rising edge
//   out        delayed path output (registered)
//   out_x      one-cycle cancelled-event flag (registered)
//   pending    a transition is scheduled and not yet applied
//   cancel_cnt cancelled transitions, saturates at 255
module inertial_path_delay #(
    parameter int RISE_DLY       = 2,
    parameter int FALL_DLY       = 3,
    parameter int SHOW_CANCELLED = 0,
    parameter int ON_DETECT      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic       out,
    output logic       out_x,
    output logic       pending,
    output logic [7:0] cancel_cnt
);

    typedef enum logic {IDLE, PEND} state_t;
    typedef enum logic {SH_IDLE, SH_RUN} sh_state_t;

    // Countdown reload values: loaded at the scheduling edge, the output
    // is applied at the edge where the countdown reads zero.
    localparam logic [3:0] RISE_LOAD = 4'(RISE_DLY - 1);
    localparam logic [3:0] FALL_LOAD = 4'(FALL_DLY - 1);

    localparam bit USE_DETECT = (SHOW_CANCELLED != 0) && (ON_DETECT != 0);
    localparam bit USE_SHADOW = (SHOW_CANCELLED != 0) && (ON_DETECT == 0);

    state_t     state, state_d;
    sh_state_t  sh_state, sh_state_d;
    logic       tv, tv_d;
    logic [3:0] cnt, cnt_d;
    logic [3:0] sh_cnt, sh_cnt_d;
    logic       out_d;
    logic       out_x_d;
    logic [7:0] cancel_cnt_d;
    logic       start;
    logic       cancel;

    always_comb begin
        state_d      = state;
        sh_state_d   = sh_state;
        tv_d         = tv;
        cnt_d        = cnt;
        sh_cnt_d     = sh_cnt;
        out_d        = out;
        out_x_d      = 1'b0;
        cancel_cnt_d = cancel_cnt;
        start        = 1'b0;
        cancel       = 1'b0;

        unique case (state)
            IDLE: begin
                if (din != out) begin
                    start = 1'b1;
                end
            end
            PEND: begin
                if (cnt == 4'd0) begin
                    // Apply; din at this same edge is compared against the
                    // new output so a following edge is scheduled at once.
                    out_d = tv;
                    if (din != tv) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (din != tv) begin
                    cancel  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = PEND;
            tv_d    = din;
            cnt_d   = din ? RISE_LOAD : FALL_LOAD;
        end

        if (cancel && (cancel_cnt != 8'hFF)) begin
            cancel_cnt_d = cancel_cnt + 8'd1;
        end

        if (USE_SHADOW) begin
            if (sh_state == SH_RUN) begin
                if (sh_cnt == 4'd0) begin
                    out_x_d    = 1'b1;
                    sh_state_d = SH_IDLE;
                end else begin
                    sh_cnt_d = sh_cnt - 4'd1;
                end
            end
            // A new cancel restarts the shadow; an expiring shadow still
            // raises its flag on this edge before being reloaded.
            if (cancel) begin
                sh_state_d = SH_RUN;
                sh_cnt_d   = cnt - 4'd1;
            end
        end

        if (USE_DETECT && cancel) begin
            out_x_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh_state   <= SH_IDLE;
            tv         <= 1'b0;
            cnt        <= '0;
            sh_cnt     <= '0;
            out        <= 1'b0;
            out_x      <= 1'b0;
            cancel_cnt <= '0;
        end else begin
            state      <= state_d;
            sh_state   <= sh_state_d;
            tv         <= tv_d;
            cnt        <= cnt_d;
            sh_cnt     <= sh_cnt_d;
            out        <= out_d;
            out_x      <= out_x_d;
            cancel_cnt <= cancel_cnt_d;
        end
    end

    assign pending = (state == PEND);

endmodule
